mem_port_arbiter: RTL and testbench

//  Shares the single memory port among three requesters: MMU page-table walker (PTW), data access (D), instruction fetch (I).

---
 rtl/mem_port_arbiter.sv | 226 ++++++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 450 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Memory port arbiter: shares one memory port between the page-table walker
// (PTW), data access (D) and instruction fetch (I). PTW has fixed priority
// over D, and D over I, except that I wins over D once it has lost to D
// STARVE_LIMIT times in a row. Only one transaction is outstanding at a time.
// All mem_* outputs and the per-requester read data are registered.
module mem_port_arbiter #(
    parameter int ADDR_W       = 64,
    parameter int DATA_W       = 64,
    parameter int STARVE_LIMIT = 4,
    parameter int CNT_W        = 3
) (
    input  logic                clk,
    input  logic                rst,
    // page-table walker
    input  logic                ptw_req,
    input  logic [ADDR_W-1:0]   ptw_addr,
    output logic                ptw_stall,
    output logic [DATA_W-1:0]   ptw_rdata,
    // data access
    input  logic                d_req,
    input  logic                d_we,
    input  logic [ADDR_W-1:0]   d_addr,
    input  logic [DATA_W-1:0]   d_wdata,
    input  logic [DATA_W/8-1:0] d_wmask,
    output logic                d_stall,
    output logic [DATA_W-1:0]   d_rdata,
    // instruction fetch
    input  logic                i_req,
    input  logic [ADDR_W-1:0]   i_addr,
    input  logic                i_flush,
    output logic                i_stall,
    output logic [DATA_W-1:0]   i_rdata,
    // memory port
    output logic                mem_req,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_wmask,
    input  logic                mem_gnt,
    input  logic                mem_rvalid,
    input  logic [DATA_W-1:0]   mem_rdata
);

    localparam int MASK_W = DATA_W / 8;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam logic [1:0] OWN_PTW = 2'd0;
    localparam logic [1:0] OWN_D   = 2'd1;
    localparam logic [1:0] OWN_I   = 2'd2;

    localparam logic [CNT_W-1:0] STARVE_MAX = CNT_W'(STARVE_LIMIT);

    logic [1:0]        state_q, state_d;
    logic [1:0]        owner_q, owner_d;
    logic              dropped_q, dropped_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              mem_req_q, mem_req_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic [MASK_W-1:0] mem_wmask_q, mem_wmask_d;
    logic [DATA_W-1:0] ptw_rdata_q, ptw_rdata_d;
    logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
    logic [DATA_W-1:0] i_rdata_q, i_rdata_d;

    logic [1:0]        sel;
    logic              i_flush_hit;

    // Next-state logic: arbitration, memory handshake and response capture.
    always_comb begin
        // NOTE: every variable gets a default here so no path leaves one
        // unassigned, which would otherwise infer a latch.
        state_d     = state_q;
        owner_d     = owner_q;
        dropped_d   = dropped_q;
        cnt_d       = cnt_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_wmask_d = mem_wmask_q;
        ptw_rdata_d = ptw_rdata_q;
        d_rdata_d   = d_rdata_q;
        i_rdata_d   = i_rdata_q;
        sel         = OWN_I;

        // A redirect only matters while a fetch owns the port.
        i_flush_hit = i_flush && (owner_q == OWN_I);

        case (state_q)
            S_IDLE: begin
                if (!i_req) begin
                    cnt_d = '0;
                end
                if (ptw_req || d_req || i_req) begin
                    if (ptw_req) begin
                        sel = OWN_PTW;
                    end else if (i_req && (cnt_q >= STARVE_MAX)) begin
                        sel = OWN_I;
                    end else if (d_req) begin
                        sel = OWN_D;
                    end else begin
                        sel = OWN_I;
                    end

                    case (sel)
                        OWN_PTW: begin
                            mem_we_d    = 1'b0;
                            mem_addr_d  = ptw_addr;
                            mem_wdata_d = '0;
                            mem_wmask_d = '1;
                        end
                        OWN_D: begin
                            mem_we_d    = d_we;
                            mem_addr_d  = d_addr;
                            mem_wdata_d = d_wdata;
                            mem_wmask_d = d_wmask;
                            if (i_req && (cnt_q < STARVE_MAX)) begin
                                cnt_d = cnt_q + CNT_W'(1);
                            end
                        end
                        default: begin
                            mem_we_d    = 1'b0;
                            mem_addr_d  = i_addr;
                            mem_wdata_d = '0;
                            mem_wmask_d = '1;
                            cnt_d       = '0;
                        end
                    endcase

                    owner_d   = sel;
                    dropped_d = 1'b0;
                    mem_req_d = 1'b1;
                    state_d   = S_ISSUE;
                end
            end

            S_ISSUE: begin
                if (i_flush_hit) begin
                    dropped_d = 1'b1;
                end
                if (mem_gnt) begin
                    mem_req_d = 1'b0;
                    state_d   = S_WAIT;
                end
            end

            S_WAIT: begin
                if (i_flush_hit) begin
                    dropped_d = 1'b1;
                end
                if (mem_rvalid) begin
                    case (owner_q)
                        OWN_PTW: ptw_rdata_d = mem_rdata;
                        OWN_D:   d_rdata_d   = mem_rdata;
                        default: begin
                            if (!(dropped_q || i_flush_hit)) begin
                                i_rdata_d = mem_rdata;
                            end
                        end
                    endcase
                    state_d = S_DONE;
                end
            end

            default: begin
                dropped_d = 1'b0;
                state_d   = S_IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples the pre-edge value regardless of block ordering.
        if (rst) begin
            state_q     <= S_IDLE;
            owner_q     <= OWN_PTW;
            dropped_q   <= 1'b0;
            cnt_q       <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_wmask_q <= '0;
            ptw_rdata_q <= '0;
            d_rdata_q   <= '0;
            i_rdata_q   <= '0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            dropped_q   <= dropped_d;
            cnt_q       <= cnt_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_wmask_q <= mem_wmask_d;
            ptw_rdata_q <= ptw_rdata_d;
            d_rdata_q   <= d_rdata_d;
            i_rdata_q   <= i_rdata_d;
        end
    end

    // Each requester is released only in the DONE cycle of its own
    // transaction; a flushed fetch never sees a release.
    assign ptw_stall = ptw_req && !((state_q == S_DONE) && (owner_q == OWN_PTW));
    assign d_stall   = d_req   && !((state_q == S_DONE) && (owner_q == OWN_D));
    assign i_stall   = i_req   && !((state_q == S_DONE) && (owner_q == OWN_I) && !dropped_q);

    assign ptw_rdata = ptw_rdata_q;
    assign d_rdata   = d_rdata_q;
    assign i_rdata   = i_rdata_q;

    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_wmask = mem_wmask_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: a small memory responder returns
// address-derived data a programmable number of cycles after each grant.
module tb_mem_port_arbiter;

    logic        clk;
    logic        rst;
    logic        ptw_req;
    logic [63:0] ptw_addr;
    logic        ptw_stall;
    logic [63:0] ptw_rdata;
    logic        d_req;
    logic        d_we;
    logic [63:0] d_addr;
    logic [63:0] d_wdata;
    logic [7:0]  d_wmask;
    logic        d_stall;
    logic [63:0] d_rdata;
    logic        i_req;
    logic [63:0] i_addr;
    logic        i_flush;
    logic        i_stall;
    logic [63:0] i_rdata;
    logic        mem_req;
    logic        mem_we;
    logic [63:0] mem_addr;
    logic [63:0] mem_wdata;
    logic [7:0]  mem_wmask;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [63:0] mem_rdata;

    int n_cmp = 0;
    int n_bad = 0;
    logic prev_req = 1'b0;

    // responder controls
    int          rv_delay   = 2;
    int          rv_count   = 0;
    logic        fixed_en   = 1'b0;
    logic [63:0] fixed_data = 64'h0;
    logic [63:0] pend_data  = 64'h0;
    logic        rsp_hs;
    logic [63:0] rsp_d;

    mem_port_arbiter #(
        .ADDR_W(64), .DATA_W(64), .STARVE_LIMIT(4), .CNT_W(3)
    ) dut (
        .clk(clk), .rst(rst),
        .ptw_req(ptw_req), .ptw_addr(ptw_addr), .ptw_stall(ptw_stall), .ptw_rdata(ptw_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_wmask(d_wmask),
        .d_stall(d_stall), .d_rdata(d_rdata),
        .i_req(i_req), .i_addr(i_addr), .i_flush(i_flush), .i_stall(i_stall), .i_rdata(i_rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_wmask(mem_wmask), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [63:0] resp_of(input logic [63:0] a);
        return a ^ 64'hA5A5_0000_0000_0000;
    endfunction

    // Memory model: a handshake (mem_req & mem_gnt at an edge) schedules one
    // rvalid pulse rv_delay cycles later, independent of the arbiter state.
    always @(posedge clk) begin
        rsp_hs = mem_req && mem_gnt;
        rsp_d  = fixed_en ? fixed_data : resp_of(mem_addr);
        #1;
        mem_rvalid = 1'b0;
        if (rsp_hs) begin
            if (rv_delay <= 1) begin
                mem_rvalid = 1'b1;
                mem_rdata  = rsp_d;
            end else begin
                rv_count  = rv_delay - 1;
                pend_data = rsp_d;
            end
        end else if (rv_count > 0) begin
            rv_count = rv_count - 1;
            if (rv_count == 0) begin
                mem_rvalid = 1'b1;
                mem_rdata  = pend_data;
            end
        end
    end

    task automatic step();
        prev_req = mem_req;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_rise(input string tag, input int budget);
        bit got = 0;
        for (int c = 0; c < budget && !got; c++) begin
            step();
            if (mem_req && !prev_req) got = 1;
        end
        n_cmp++;
        if (!got) begin
            n_bad++;
            $display("FAIL %s: no mem_req rise within %0d cycles", tag, budget);
        end
    endtask

    // who: 0=PTW 1=D 2=I; returns number of steps until that stall drops
    task automatic wait_done(input string tag, input int who, input int budget, output int cycles);
        bit got = 0;
        cycles = -1;
        for (int c = 1; c <= budget && !got; c++) begin
            step();
            if ((who == 0 && !ptw_stall) || (who == 1 && !d_stall) || (who == 2 && !i_stall)) begin
                got = 1;
                cycles = c;
            end
        end
        n_cmp++;
        if (!got) begin
            n_bad++;
            $display("FAIL %s: stall never dropped within %0d cycles", tag, budget);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        n_cmp++;
        if ({mem_req, mem_we, mem_addr, mem_wdata, mem_wmask} !== '0) begin
            n_bad++;
            $display("FAIL reset_mem: got req=%b we=%b addr=%h wdata=%h wmask=%h, want all 0",
                     mem_req, mem_we, mem_addr, mem_wdata, mem_wmask);
        end
        n_cmp++;
        if ({ptw_rdata, d_rdata, i_rdata} !== '0) begin
            n_bad++;
            $display("FAIL reset_rdata: got %h %h %h, want 0", ptw_rdata, d_rdata, i_rdata);
        end
        ptw_addr = 64'h40;
        ptw_req  = 1'b1;
        step();
        n_cmp++;
        if ({mem_req, ptw_stall} !== 2'b01) begin
            n_bad++;
            $display("FAIL reset_hold: got mem_req=%b ptw_stall=%b, want 0/1", mem_req, ptw_stall);
        end
        ptw_req = 1'b0;
        rst     = 1'b0;
        step();
    endtask

    task automatic test_priority();
        int order[$];
        int exp_order[3] = '{0, 1, 2};
        ptw_addr = 64'h1000;
        d_addr   = 64'h2000;
        d_we     = 1'b0;
        i_addr   = 64'h3000;
        mem_gnt  = 1'b1;
        rv_delay = 2;
        ptw_req  = 1'b1;
        d_req    = 1'b1;
        i_req    = 1'b1;
        for (int c = 0; c < 60 && (ptw_req || d_req || i_req); c++) begin
            step();
            if (mem_req && !prev_req) begin
                if (mem_addr == ptw_addr)      order.push_back(0);
                else if (mem_addr == d_addr)   order.push_back(1);
                else if (mem_addr == i_addr)   order.push_back(2);
                else                           order.push_back(3);
            end
            if (ptw_req && !ptw_stall) begin
                n_cmp++;
                if ({ptw_rdata, d_stall, i_stall} !== {resp_of(64'h1000), 2'b11}) begin
                    n_bad++;
                    $display("FAIL prio_ptw_done: got rdata=%h d_stall=%b i_stall=%b, want %h 1 1",
                             ptw_rdata, d_stall, i_stall, resp_of(64'h1000));
                end
                ptw_req = 1'b0;
            end
            if (d_req && !d_stall) begin
                n_cmp++;
                if ({d_rdata, i_stall} !== {resp_of(64'h2000), 1'b1}) begin
                    n_bad++;
                    $display("FAIL prio_d_done: got rdata=%h i_stall=%b, want %h 1",
                             d_rdata, i_stall, resp_of(64'h2000));
                end
                d_req = 1'b0;
            end
            if (i_req && !i_stall) begin
                n_cmp++;
                if (i_rdata !== resp_of(64'h3000)) begin
                    n_bad++;
                    $display("FAIL prio_i_done: got %h want %h", i_rdata, resp_of(64'h3000));
                end
                i_req = 1'b0;
            end
        end
        n_cmp++;
        if ({ptw_req, d_req, i_req} !== 3'b000) begin
            n_bad++;
            $display("FAIL prio_complete: pending reqs %b, want 000", {ptw_req, d_req, i_req});
        end
        n_cmp++;
        if (order.size() != 3 || order[0] != exp_order[0] || order[1] != exp_order[1] ||
            order[2] != exp_order[2]) begin
            n_bad++;
            $display("FAIL prio_order: got %0d grants %p, want PTW,D,I (0,1,2)", order.size(), order);
        end
        step();
    endtask

    task automatic test_gnt_stall();
        int cyc;
        mem_gnt  = 1'b0;
        ptw_addr = 64'h8000_1000;
        ptw_req  = 1'b1;
        wait_rise("gnt_stall_rise", 10);
        for (int k = 0; k < 5; k++) begin
            n_cmp++;
            if ({mem_req, mem_we, mem_wmask, ptw_stall, mem_addr} !==
                {1'b1, 1'b0, 8'hFF, 1'b1, 64'h8000_1000}) begin
                n_bad++;
                $display("FAIL gnt_hold[%0d]: got req=%b we=%b mask=%h stall=%b addr=%h, want 1 0 ff 1 80001000",
                         k, mem_req, mem_we, mem_wmask, ptw_stall, mem_addr);
            end
            step();
        end
        mem_gnt = 1'b1;
        wait_done("gnt_stall_done", 0, 10, cyc);
        n_cmp++;
        if (ptw_rdata !== resp_of(64'h8000_1000)) begin
            n_bad++;
            $display("FAIL gnt_stall_rdata: got %h want %h", ptw_rdata, resp_of(64'h8000_1000));
        end
        ptw_req = 1'b0;
        step();
    endtask

    task automatic test_starvation();
        int d_grants = 0;
        int d_before_i = -1;
        bit i_done = 0;
        int cyc;
        mem_gnt = 1'b1;
        d_we    = 1'b0;
        d_addr  = 64'h4000;
        i_addr  = 64'h5000;
        d_req   = 1'b1;
        i_req   = 1'b1;
        for (int c = 0; c < 100 && !i_done; c++) begin
            step();
            if (mem_req && !prev_req) begin
                if (mem_addr == i_addr && d_before_i < 0) d_before_i = d_grants;
                else if (mem_addr == d_addr) d_grants++;
            end
            if (d_req && !d_stall) begin
                n_cmp++;
                if (d_rdata !== resp_of(d_addr)) begin
                    n_bad++;
                    $display("FAIL starve_d_rdata: got %h want %h", d_rdata, resp_of(d_addr));
                end
                d_addr = d_addr + 64'h40;
            end
            if (i_req && !i_stall) begin
                n_cmp++;
                if (i_rdata !== resp_of(64'h5000)) begin
                    n_bad++;
                    $display("FAIL starve_i_rdata: got %h want %h", i_rdata, resp_of(64'h5000));
                end
                i_req  = 1'b0;
                i_done = 1;
            end
        end
        n_cmp++;
        if (d_before_i != 4) begin
            n_bad++;
            $display("FAIL starve_count: I granted after %0d D grants, want 4", d_before_i);
        end
        // counter must have restarted: D wins the next contest again
        step();
        i_req = 1'b1;
        wait_rise("starve_after_rise", 10);
        n_cmp++;
        if (mem_addr !== d_addr) begin
            n_bad++;
            $display("FAIL starve_cnt_cleared: next grant addr %h, want D addr %h", mem_addr, d_addr);
        end
        wait_done("starve_after_d", 1, 10, cyc);
        d_req = 1'b0;
        wait_done("starve_after_i", 2, 20, cyc);
        i_req = 1'b0;
        step();
    endtask

    task automatic test_flush();
        bit low_seen = 0;
        bit got = 0;
        int cyc;
        fixed_en   = 1'b1;
        fixed_data = 64'hDEAD;
        rv_delay   = 4;
        mem_gnt    = 1'b1;
        i_addr     = 64'h6000;
        i_req      = 1'b1;
        wait_rise("flush_rise", 10);
        step();
        i_flush = 1'b1;
        step();
        i_flush  = 1'b0;
        fixed_en = 1'b0;
        if (!i_stall) low_seen = 1;
        for (int c = 0; c < 20 && !got; c++) begin
            step();
            if (mem_req && !prev_req) got = 1;
            else if (!i_stall) low_seen = 1;
        end
        n_cmp++;
        if (low_seen || !got) begin
            n_bad++;
            $display("FAIL flush_stall: stall dropped=%b reissued=%b, want 0 1", low_seen, got);
        end
        n_cmp++;
        if ({i_rdata, mem_addr} !== {resp_of(64'h5000), 64'h6000}) begin
            n_bad++;
            $display("FAIL flush_rdata: got rdata=%h addr=%h, want %h 6000",
                     i_rdata, mem_addr, resp_of(64'h5000));
        end
        wait_done("flush_refetch", 2, 20, cyc);
        n_cmp++;
        if (i_rdata !== resp_of(64'h6000)) begin
            n_bad++;
            $display("FAIL flush_refetch_rdata: got %h want %h", i_rdata, resp_of(64'h6000));
        end
        i_req    = 1'b0;
        rv_delay = 2;
        step();
    endtask

    task automatic test_reset_mid();
        int cyc;
        rv_delay = 3;
        mem_gnt  = 1'b1;
        d_we     = 1'b0;
        d_addr   = 64'h7000;
        d_req    = 1'b1;
        wait_rise("rstmid_rise", 10);
        step();
        rst     = 1'b1;
        mem_gnt = 1'b0;
        step();
        rst = 1'b0;
        n_cmp++;
        if ({mem_req, ptw_rdata, d_rdata, i_rdata} !== '0) begin
            n_bad++;
            $display("FAIL rstmid_clear: got req=%b rdata=%h/%h/%h, want all 0",
                     mem_req, ptw_rdata, d_rdata, i_rdata);
        end
        for (int k = 0; k < 4; k++) begin
            step();
            n_cmp++;
            if ({d_stall, d_rdata} !== {1'b1, 64'h0}) begin
                n_bad++;
                $display("FAIL rstmid_late_rvalid[%0d]: got stall=%b rdata=%h, want 1 0", k, d_stall, d_rdata);
            end
        end
        n_cmp++;
        if ({mem_req, mem_addr} !== {1'b1, 64'h7000}) begin
            n_bad++;
            $display("FAIL rstmid_rearb: got req=%b addr=%h, want 1 7000", mem_req, mem_addr);
        end
        rv_delay = 2;
        mem_gnt  = 1'b1;
        wait_done("rstmid_done", 1, 10, cyc);
        n_cmp++;
        if (d_rdata !== resp_of(64'h7000)) begin
            n_bad++;
            $display("FAIL rstmid_rdata: got %h want %h", d_rdata, resp_of(64'h7000));
        end
        d_req = 1'b0;
        step();
    endtask

    task automatic test_write();
        int cyc;
        rv_delay = 2;
        mem_gnt  = 1'b1;
        d_we     = 1'b1;
        d_wmask  = 8'h0F;
        d_wdata  = 64'h1122334455667788;
        d_addr   = 64'h9000;
        d_req    = 1'b1;
        wait_rise("write_rise", 10);
        n_cmp++;
        if ({mem_we, mem_wmask, d_stall} !== {1'b1, 8'h0F, 1'b1}) begin
            n_bad++;
            $display("FAIL write_ctrl: got we=%b mask=%h stall=%b, want 1 0f 1", mem_we, mem_wmask, d_stall);
        end
        n_cmp++;
        if ({mem_wdata, mem_addr} !== {64'h1122334455667788, 64'h9000}) begin
            n_bad++;
            $display("FAIL write_data: got wdata=%h addr=%h, want 1122334455667788 9000", mem_wdata, mem_addr);
        end
        wait_done("write_done", 1, 10, cyc);
        n_cmp++;
        if (cyc != 3) begin
            n_bad++;
            $display("FAIL write_latency: d_stall dropped %0d cycles after issue, want 3", cyc);
        end
        d_req = 1'b0;
        d_we  = 1'b0;
        step();
    endtask

    initial begin
        rst        = 1'b1;
        ptw_req    = 1'b0;
        ptw_addr   = '0;
        d_req      = 1'b0;
        d_we       = 1'b0;
        d_addr     = '0;
        d_wdata    = '0;
        d_wmask    = '0;
        i_req      = 1'b0;
        i_addr     = '0;
        i_flush    = 1'b0;
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b0;
        mem_rdata  = '0;

        test_reset();
        test_priority();
        test_gnt_stall();
        test_starvation();
        test_flush();
        test_reset_mid();
        test_write();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
